fc_layer_par: RTL and testbench

Parametrised fully-connected layer engine computing y = W·x for an M×N signed weight matrix and length-N input vector.
- Successor to the fixed-size, single-lane, ROM-weight FC blocks: P parallel MAC lanes, runtime-loadable weight RAM, output saturation and optional ReLU.
- Sits between streaming producer/consumer stages using valid/ready handshakes on input and output.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_layer_par_lane.sv | 49 ++++
 rtl/fc_layer_par.sv | 140 ++++++++++++++
 tb/tb_fc_layer_par.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the parallel fully-connected layer engine.
package fc_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   // Each product needs 2T bits; summing N of them needs clog2(N) guard bits.
   function automatic int acc_width(input int t, input int n);
      return 2 * t + $clog2(n);
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int t);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (t - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (t - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic signed [63:0] relu(input logic signed [63:0] v);
      return (v < 64'sd0) ? 64'sd0 : v;
   endfunction

endpackage

// File: rtl/fc_layer_par_lane.sv
// One MAC lane: private weight bank, registered read, multiply-accumulate and
// saturating (optionally rectified) result.
module fc_mac_lane
   import fc_pkg::*;
#(
   parameter int T     = 16,
   parameter int DEPTH = 16,
   parameter int BW    = 4,
   parameter int ACC_W = 35,
   parameter int RELU  = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [BW-1:0]       wr_addr,
   input  logic signed [T-1:0] wr_data,
   input  logic [BW-1:0]       rd_addr,
   input  logic signed [T-1:0] x_data,
   input  logic                clr,
   input  logic                mac_en,
   output logic signed [T-1:0] result
);

   logic signed [T-1:0]     mem [DEPTH];
   logic signed [T-1:0]     w_q;
   logic signed [2*T-1:0]   prod;
   logic signed [ACC_W-1:0] acc;
   logic signed [63:0]      sat_v;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      w_q <= mem[rd_addr];
   end

   assign prod = w_q * x_data;

   always_ff @(posedge clk) begin
      if (reset)       acc <= '0;
      else if (clr)    acc <= '0;
      else if (mac_en) acc <= acc + ACC_W'(prod);
   end

   always_comb begin
      sat_v = saturate(64'(acc), T);
      if (RELU != 0) sat_v = relu(sat_v);
      result = T'(sat_v);
   end

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer y = W*x with P parallel MAC lanes, loadable weight banks
// and valid/ready streaming on input and output.
module fc_layer_par
   import fc_pkg::*;
#(
   parameter int M    = 16,
   parameter int N    = 8,
   parameter int T    = 16,
   parameter int P    = 2,
   parameter int RELU = 0,
   localparam int AW  = (M * N > 1) ? $clog2(M * N) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                input_valid,
   output logic                input_ready,
   input  logic signed [T-1:0] input_data,
   output logic                output_valid,
   input  logic                output_ready,
   output logic signed [T-1:0] output_data,
   input  logic                w_wr_en,
   input  logic [AW-1:0]       w_addr,
   input  logic signed [T-1:0] w_data,
   output logic                w_ready
);

   localparam int G     = M / P;
   localparam int DEPTH = G * N;
   localparam int BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ACC_W = acc_width(T, N);
   localparam int CW    = $clog2(N + P + 1);
   localparam int GW    = (G > 1) ? $clog2(G) : 1;
   localparam int XW    = (N > 1) ? $clog2(N) : 1;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [GW-1:0]       grp, grp_n;
   logic signed [T-1:0] x_buf [N];
   logic signed [T-1:0] x_q;
   logic                in_fire, out_fire, issue, clr, mac_en;
   logic [BW-1:0]       rd_addr, wr_addr;
   logic [P-1:0]        wr_en;
   logic signed [T-1:0] lane_res [P];
   int                  w_row, w_col;

   assign input_ready  = (state == LOAD);
   assign w_ready      = (state == LOAD) && (cnt == '0);
   assign output_valid = (state == OUTPUT);
   assign in_fire      = input_valid && input_ready;
   assign out_fire     = output_valid && output_ready;
   assign issue        = (state == COMPUTE) && (cnt < CW'(N));
   assign clr          = issue && (cnt == '0);
   assign rd_addr      = BW'(int'(grp) * N + int'(cnt));

   // Row r lives in bank r%P at local row r/P, so a group's P rows share one address.
   always_comb begin
      w_row   = int'(w_addr) / N;
      w_col   = int'(w_addr) % N;
      wr_addr = BW'((w_row / P) * N + w_col);
      wr_en   = '0;
      for (int p = 0; p < P; p++)
         if (w_wr_en && w_ready && (w_row % P == p)) wr_en[p] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (in_fire) x_buf[XW'(cnt)] <= input_data;
      if (issue)   x_q <= x_buf[XW'(cnt)];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= LOAD;
         cnt    <= '0;
         grp    <= '0;
         mac_en <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         grp    <= grp_n;
         mac_en <= issue;
      end
   end

   // cnt counts inputs in LOAD, issue cycles in COMPUTE and lanes in OUTPUT.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      grp_n   = grp;
      case (state)
         LOAD: if (in_fire) begin
            if (cnt == CW'(N - 1)) begin
               state_n = COMPUTE;
               cnt_n   = '0;
               grp_n   = '0;
            end else cnt_n = cnt + 1'b1;
         end
         COMPUTE: begin
            if (cnt == CW'(N)) begin
               state_n = OUTPUT;
               cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
         end
         OUTPUT: if (out_fire) begin
            if (cnt == CW'(P - 1)) begin
               cnt_n = '0;
               if (grp == GW'(G - 1)) state_n = LOAD;
               else begin
                  grp_n   = grp + 1'b1;
                  state_n = COMPUTE;
               end
            end else cnt_n = cnt + 1'b1;
         end
         default: state_n = LOAD;
      endcase
   end

   always_comb begin
      output_data = '0;
      for (int p = 0; p < P; p++)
         if (state == OUTPUT && cnt == CW'(p)) output_data = lane_res[p];
   end

   for (genvar p = 0; p < P; p++) begin : g_lane
      fc_mac_lane #(
         .T(T), .DEPTH(DEPTH), .BW(BW), .ACC_W(ACC_W), .RELU(RELU)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (wr_en[p]),
         .wr_addr (wr_addr),
         .wr_data (w_data),
         .rd_addr (rd_addr),
         .x_data  (x_q),
         .clr     (clr),
         .mac_en  (mac_en),
         .result  (lane_res[p])
      );
   end

endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: a RELU=0 and a RELU=1 instance share all inputs and are
// checked against a matrix-vector reference computed with plain integer arithmetic.
module tb_fc_layer_par;

   localparam int M  = 4;
   localparam int N  = 2;
   localparam int T  = 16;
   localparam int P  = 2;
   localparam int AW = $clog2(M * N);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          input_valid = 1'b0;
   logic [T-1:0]  input_data = '0;
   logic          output_ready = 1'b0;
   logic          w_wr_en = 1'b0;
   logic [AW-1:0] w_addr = '0;
   logic [T-1:0]  w_data = '0;
   logic          input_ready0, output_valid0, w_ready0;
   logic          input_ready1, output_valid1, w_ready1;
   logic [T-1:0]  output_data0, output_data1;

   int checks = 0;
   int errors = 0;
   int wm [M][N];
   int xv [N];

   always #5 clk = ~clk;

   fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .RELU(0)) dut0 (
      .clk(clk), .reset(reset),
      .input_valid(input_valid), .input_ready(input_ready0), .input_data(input_data),
      .output_valid(output_valid0), .output_ready(output_ready), .output_data(output_data0),
      .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready0)
   );

   fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .RELU(1)) dut1 (
      .clk(clk), .reset(reset),
      .input_valid(input_valid), .input_ready(input_ready1), .input_data(input_data),
      .output_valid(output_valid1), .output_ready(output_ready), .output_data(output_data1),
      .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data), .w_ready(w_ready1)
   );

   function automatic int ref_y(input int r, input bit rl);
      longint s;
      s = 0;
      for (int k = 0; k < N; k++) s += longint'(wm[r][k]) * longint'(xv[k]);
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
      if (rl && s < 0) s = 0;
      return int'(s);
   endfunction

   function automatic int rnd16();
      logic [15:0] b;
      b = 16'($urandom);
      return int'($signed(b));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; input_valid = 1'b0; w_wr_en = 1'b0; output_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic load_weights();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            w_wr_en = 1'b1; w_addr = AW'(r * N + c); w_data = T'(wm[r][c]);
            checks++;
            if (w_ready0 !== 1'b1) begin
               errors++; $display("FAIL load_w_ready got %b want 1", w_ready0);
            end
            tick();
         end
      w_wr_en = 1'b0;
   endtask

   task automatic feed_vec();
      for (int k = 0; k < N; k++) begin
         input_valid = 1'b1; input_data = T'(xv[k]);
         checks++;
         if (input_ready0 !== 1'b1 || input_ready1 !== 1'b1) begin
            errors++; $display("FAIL feed_ready got %b/%b want 1", input_ready0, input_ready1);
         end
         tick();
      end
      input_valid = 1'b0;
   endtask

   // Called right after the last input was accepted.
   task automatic wait_first();
      int lat;
      lat = 1;
      while (!output_valid0 && lat < 40) begin
         checks++;
         if (input_ready0 !== 1'b0) begin
            errors++; $display("FAIL busy_ready got %b want 0 at lat %0d", input_ready0, lat);
         end
         tick(); lat++;
      end
      checks++;
      if (lat !== N + 2) begin
         errors++; $display("FAIL latency got %0d want %0d", lat, N + 2);
      end
   endtask

   task automatic collect(input int smin, input int smax);
      for (int i = 0; i < M; i++) begin
         logic [T-1:0] e0, e1;
         int n, stall;
         e0 = T'(ref_y(i, 1'b0));
         e1 = T'(ref_y(i, 1'b1));
         output_ready = 1'b0;
         n = 0;
         while (!output_valid0 && n < 40) begin tick(); n++; end
         checks++;
         if (output_valid0 !== 1'b1 || output_valid1 !== 1'b1) begin
            errors++; $display("FAIL out_valid row %0d got %b/%b want 1", i, output_valid0, output_valid1);
         end
         checks++;
         if (output_data0 !== e0) begin
            errors++; $display("FAIL y row %0d got %0d want %0d", i, $signed(output_data0), $signed(e0));
         end
         checks++;
         if (output_data1 !== e1) begin
            errors++; $display("FAIL y_relu row %0d got %0d want %0d", i, $signed(output_data1), $signed(e1));
         end
         stall = (smax > smin) ? int'($urandom_range(smax, smin)) : smin;
         repeat (stall) begin
            tick();
            checks++;
            if (output_valid0 !== 1'b1 || output_data0 !== e0) begin
               errors++; $display("FAIL stall_hold row %0d got %b/%0d want 1/%0d", i,
                                  output_valid0, $signed(output_data0), $signed(e0));
            end
         end
         output_ready = 1'b1;
         tick();
         output_ready = 1'b0;
      end
      checks++;
      if (output_valid0 !== 1'b0 || input_ready0 !== 1'b1 || w_ready0 !== 1'b1) begin
         errors++; $display("FAIL after_vec got v=%b ir=%b wr=%b want 0/1/1", output_valid0, input_ready0, w_ready0);
      end
   endtask

   task automatic set_basic_w();
      wm[0][0] = 1;  wm[0][1] = 2;
      wm[1][0] = 3;  wm[1][1] = 4;
      wm[2][0] = 5;  wm[2][1] = 6;
      wm[3][0] = -7; wm[3][1] = -8;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (input_ready0 !== 1'b1 || output_valid0 !== 1'b0 || output_data0 !== '0 || w_ready0 !== 1'b1) begin
         errors++; $display("FAIL reset_state got ir=%b v=%b d=%h wr=%b want 1/0/0000/1",
                            input_ready0, output_valid0, output_data0, w_ready0);
      end
   endtask

   task automatic test_basic();
      set_basic_w();
      load_weights();
      xv[0] = 10; xv[1] = 20;
      feed_vec(); wait_first(); collect(0, 0);
   endtask

   task automatic test_saturate();
      wm[0][0] = 32767;  wm[0][1] = 32767;
      wm[1][0] = -32768; wm[1][1] = -32768;
      wm[2][0] = -32768; wm[2][1] = 32767;
      wm[3][0] = 100;    wm[3][1] = -3;
      load_weights();
      xv[0] = 32767; xv[1] = 32767;
      feed_vec(); wait_first(); collect(0, 2);
   endtask

   task automatic test_stall();
      for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) wm[r][c] = rnd16() % 200;
      load_weights();
      xv[0] = rnd16() % 300; xv[1] = rnd16() % 300;
      feed_vec(); wait_first(); collect(5, 5);
   endtask

   task automatic test_reset_mid();
      set_basic_w();
      load_weights();
      xv[0] = 9; xv[1] = 9;
      feed_vec();
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (input_ready0 !== 1'b1 || output_valid0 !== 1'b0) begin
         errors++; $display("FAIL abort_state got ir=%b v=%b want 1/0", input_ready0, output_valid0);
      end
      repeat (6) begin
         tick();
         checks++;
         if (output_valid0 !== 1'b0) begin
            errors++; $display("FAIL stale_out got %b want 0", output_valid0);
         end
      end
      xv[0] = 1; xv[1] = 1;
      feed_vec(); wait_first(); collect(0, 1);
   endtask

   task automatic test_drop_write();
      xv[0] = 10; xv[1] = 20;
      input_valid = 1'b1; input_data = T'(xv[0]);
      tick();
      input_valid = 1'b0;
      w_wr_en = 1'b1; w_addr = '0; w_data = T'(99);
      checks++;
      if (w_ready0 !== 1'b0) begin
         errors++; $display("FAIL drop_w_ready got %b want 0", w_ready0);
      end
      tick();
      w_wr_en = 1'b0;
      input_valid = 1'b1; input_data = T'(xv[1]);
      tick();
      input_valid = 1'b0;
      wait_first(); collect(0, 0);
   endtask

   task automatic test_simul_write();
      xv[0] = 3; xv[1] = -2;
      w_wr_en = 1'b1; w_addr = AW'(1 * N + 1); w_data = T'(-9);
      input_valid = 1'b1; input_data = T'(xv[0]);
      checks++;
      if (w_ready0 !== 1'b1) begin
         errors++; $display("FAIL simul_w_ready got %b want 1", w_ready0);
      end
      tick();
      wm[1][1] = -9;
      w_wr_en = 1'b0;
      checks++;
      if (w_ready0 !== 1'b0) begin
         errors++; $display("FAIL simul_w_drop got %b want 0", w_ready0);
      end
      input_data = T'(xv[1]);
      tick();
      input_valid = 1'b0;
      wait_first(); collect(0, 1);
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 6; it++) begin
         if (it % 2 == 0) begin
            for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) wm[r][c] = rnd16();
            load_weights();
         end
         for (int k = 0; k < N; k++) xv[k] = (it < 3) ? rnd16() : rnd16() % 64;
         feed_vec(); wait_first(); collect(0, 3);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_stall();
      test_reset_mid();
      test_drop_write();
      test_simul_write();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
